// File: rtl/asg_pkg.sv
// Shared definitions for the alternating step generator family: LFSR width,
// feedback taps, checker states and the common LFSR step function.
package asg_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_A  = 3;
  localparam int TAP_B  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  // x^4+x^3+1: shift left, feed back the XOR of the top two bits (period 15)
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B]};
  endfunction

endpackage

// File: rtl/asg_keystream.sv
// Three LFSRs with alternating-step clocking. The control register's MSB picks
// which data register steps; the output word is the XOR of the two data LFSRs.
module asg_keystream
  import asg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [LFSR_W-1:0] ctrl_seed,
  input  logic [LFSR_W-1:0] seed_0,
  input  logic [LFSR_W-1:0] seed_1,
  output logic [LFSR_W-1:0] word
);

  logic [LFSR_W-1:0] ctrl;
  logic [LFSR_W-1:0] r0;
  logic [LFSR_W-1:0] r1;

  // Seed load takes priority; otherwise one alternating step per advance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
      r0   <= '0;
      r1   <= '0;
    end else if (load) begin
      ctrl <= ctrl_seed;
      r0   <= seed_0;
      r1   <= seed_1;
    end else if (advance) begin
      ctrl <= lfsr_step(ctrl);
      if (ctrl[LFSR_W-1]) r1 <= lfsr_step(r1);
      else                r0 <= lfsr_step(r0);
    end
  end

  assign word = r0 ^ r1;

endmodule

// File: rtl/asg_stream_checker.sv
// Receive-side ASG checker: regenerates the keystream from the seeds and
// compares it against incoming words, tracking lock/fail and error counts.
module asg_stream_checker
  import asg_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int FAIL_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] ctrl_seed,
  input  logic [LFSR_W-1:0] seed_0,
  input  logic [LFSR_W-1:0] seed_1,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  output logic [LFSR_W-1:0] expected,
  output logic              locked,
  output logic              fail,
  output logic              seed_err,
  output logic              mismatch,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int FW = $clog2(FAIL_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(FAIL_CNT - 1);

  state_t         state;
  state_t         state_nxt;
  logic [MW-1:0]  match_cnt;
  logic [FW-1:0]  miss_cnt;
  logic           accept;
  logic           hit;
  logic           seed_zero;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A word is consumed only while the generator is running and not restarting
  assign accept    = !start && in_valid && (state == ST_ACQUIRE || state == ST_LOCKED);
  assign hit       = (in_data == expected);
  assign seed_zero = (ctrl_seed == '0) || (seed_0 == '0) || (seed_1 == '0);

  asg_keystream u_keystream (
    .clock     (clock),
    .reset     (reset),
    .load      (start),
    .advance   (accept),
    .ctrl_seed (ctrl_seed),
    .seed_0    (seed_0),
    .seed_1    (seed_1),
    .word      (expected)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: start overrides everything, otherwise advance on accepted words
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = seed_zero ? ST_FAIL : ST_ACQUIRE;
    end else if (accept) begin
      case (state)
        ST_ACQUIRE: if (hit && match_cnt == LOCK_LAST) state_nxt = ST_LOCKED;
        ST_LOCKED:  if (!hit && miss_cnt == FAIL_LAST) state_nxt = ST_FAIL;
        default:    state_nxt = state;
      endcase
    end
  end

  // Counters, seed error flag and registered mismatch pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      word_count <= '0;
      err_count  <= '0;
      mismatch   <= 1'b0;
      seed_err   <= 1'b0;
    end else if (start) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      word_count <= '0;
      err_count  <= '0;
      mismatch   <= 1'b0;
      seed_err   <= seed_zero;
    end else begin
      mismatch <= 1'b0;
      if (accept) begin
        word_count <= sat_inc(word_count);
        if (hit) begin
          if (state == ST_ACQUIRE) match_cnt <= match_cnt + 1'b1;
          miss_cnt <= '0;
        end else begin
          mismatch  <= 1'b1;
          match_cnt <= '0;
          if (state == ST_LOCKED) begin
            err_count <= sat_inc(err_count);
            miss_cnt  <= miss_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign fail   = (state == ST_FAIL);

endmodule

// File: tb/tb_asg_stream_checker.sv
// Bench for asg_stream_checker: integer-level keystream/lock model checked
// every cycle, plus directed literal expectations from hand-computed values.
module tb_asg_stream_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ctrl_seed = 4'b1001;
  logic [3:0]  seed_0 = 4'b1010;
  logic [3:0]  seed_1 = 4'b1100;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'b0000;
  logic [3:0]  expected;
  logic        locked;
  logic        fail;
  logic        seed_err;
  logic        mismatch;
  logic [15:0] word_count;
  logic [15:0] err_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses = 0;

  asg_stream_checker dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .ctrl_seed  (ctrl_seed),
    .seed_0     (seed_0),
    .seed_1     (seed_1),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .expected   (expected),
    .locked     (locked),
    .fail       (fail),
    .seed_err   (seed_err),
    .mismatch   (mismatch),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 acquiring, 2 locked, 3 failed
  int m_ctrl, m_r0, m_r1, m_mode, m_match, m_miss, m_wc, m_ec;
  bit m_mis, m_serr;
  logic [3:0] m_exp;
  logic       m_hit;
  localparam int SAT = 65535;

  function automatic int step4(input int x);
    return ((x << 1) & 15) | (((x >> 3) ^ (x >> 2)) & 1);
  endfunction

  assign m_exp = 4'(m_r0 ^ m_r1);
  assign m_hit = (in_data == m_exp);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ctrl <= 0; m_r0 <= 0; m_r1 <= 0; m_mode <= 0;
      m_match <= 0; m_miss <= 0; m_wc <= 0; m_ec <= 0;
      m_mis <= 0; m_serr <= 0;
    end else if (start) begin
      m_ctrl <= int'(ctrl_seed); m_r0 <= int'(seed_0); m_r1 <= int'(seed_1);
      m_match <= 0; m_miss <= 0; m_wc <= 0; m_ec <= 0; m_mis <= 0;
      m_serr <= (ctrl_seed == 0 || seed_0 == 0 || seed_1 == 0);
      m_mode <= (ctrl_seed == 0 || seed_0 == 0 || seed_1 == 0) ? 3 : 1;
    end else begin
      m_mis <= 0;
      if (in_valid && (m_mode == 1 || m_mode == 2)) begin
        m_ctrl <= step4(m_ctrl);
        if (m_ctrl >= 8) m_r1 <= step4(m_r1);
        else             m_r0 <= step4(m_r0);
        m_wc <= (m_wc == SAT) ? m_wc : m_wc + 1;
        if (m_hit) begin
          m_miss <= 0;
          if (m_mode == 1) begin
            m_match <= m_match + 1;
            if (m_match + 1 == 4) m_mode <= 2;
          end
        end else begin
          m_mis <= 1;
          m_match <= 0;
          if (m_mode == 2) begin
            m_ec <= (m_ec == SAT) ? m_ec : m_ec + 1;
            m_miss <= m_miss + 1;
            if (m_miss + 1 == 3) m_mode <= 3;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clock) begin
    chk("expected",   int'(expected),   int'(m_exp));
    chk("locked",     int'(locked),     (m_mode == 2) ? 1 : 0);
    chk("fail",       int'(fail),       (m_mode == 3) ? 1 : 0);
    chk("seed_err",   int'(seed_err),   int'(m_serr));
    chk("mismatch",   int'(mismatch),   int'(m_mis));
    chk("word_count", int'(word_count), m_wc);
    chk("err_count",  int'(err_count),  m_ec);
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit v, input logic [3:0] d);
    start = s; in_valid = v; in_data = d;
    @(posedge clock); #1;
    if (mismatch) pulses++;
  endtask

  task automatic good();
    step(1'b0, 1'b1, m_exp);
  endtask

  task automatic bad();
    step(1'b0, 1'b1, m_exp ^ 4'b0001);
  endtask

  task automatic std_start();
    ctrl_seed = 4'b1001; seed_0 = 4'b1010; seed_1 = 4'b1100;
    step(1'b1, 1'b0, 4'b0000);
  endtask

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("rst_expected", int'(expected), 0);
    chk("rst_word_count", int'(word_count), 0);
    chk("rst_locked", int'(locked), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    step(1'b0, 1'b1, 4'b0000);            // IDLE ignores valid
    chk("idle_word_count", int'(word_count), 0);

    // Acquire and lock with the standard seeds
    std_start();
    chk("start_expected", int'(expected), 4'b0110);
    step(1'b0, 1'b1, 4'b0110);
    chk("w1_expected", int'(expected), 4'b0010);
    step(1'b0, 1'b1, 4'b0010);
    chk("w2_expected", int'(expected), 4'b1101);
    step(1'b0, 1'b1, 4'b1101);
    chk("w3_expected", int'(expected), 4'b0011);
    chk("w3_locked", int'(locked), 0);
    step(1'b0, 1'b1, 4'b0011);
    chk("w4_locked", int'(locked), 1);
    chk("w4_word_count", int'(word_count), 4);
    chk("w4_err_count", int'(err_count), 0);
    chk("w4_expected", int'(expected), 4'b1010);

    // Single corrupted word while locked
    step(1'b0, 1'b1, 4'b1011);
    chk("corrupt_mismatch", int'(mismatch), 1);
    chk("corrupt_err_count", int'(err_count), 1);
    chk("corrupt_locked", int'(locked), 1);
    good();
    chk("pulse_single", int'(mismatch), 0);
    // A match between misses resets the consecutive-miss run
    bad(); bad(); good(); bad(); bad();
    chk("run_reset_locked", int'(locked), 1);
    chk("run_reset_err_count", int'(err_count), 5);
    good();

    // Three consecutive misses force FAIL
    std_start();
    repeat (4) good();
    bad(); bad(); bad();
    chk("fail_err_count", int'(err_count), 3);
    chk("fail_flag", int'(fail), 1);
    chk("fail_locked", int'(locked), 0);
    chk("fail_word_count", int'(word_count), 7);
    good(); bad();
    chk("fail_frozen_count", int'(word_count), 7);

    // Mismatch during acquisition restarts the match run; valid on start ignored
    ctrl_seed = 4'b1001; seed_0 = 4'b1010; seed_1 = 4'b1100;
    step(1'b1, 1'b1, 4'b0110);
    chk("start_valid_ignored", int'(word_count), 0);
    pulses = 0;
    good(); good(); bad(); good(); good(); good();
    chk("acq6_locked", int'(locked), 0);
    good();
    chk("acq7_locked", int'(locked), 1);
    chk("acq_err_count", int'(err_count), 0);
    chk("acq_pulses", pulses, 1);

    // Zero seed goes straight to FAIL, valid seeds recover
    seed_1 = 4'b0000;
    step(1'b1, 1'b0, 4'b0000);
    chk("zseed_err", int'(seed_err), 1);
    chk("zseed_fail", int'(fail), 1);
    std_start();
    chk("reseed_err", int'(seed_err), 0);
    chk("reseed_fail", int'(fail), 0);
    chk("reseed_expected", int'(expected), 4'b0110);
    good();
    chk("reseed_acquire", int'(word_count), 1);

    // Asynchronous reset in the middle of acquisition
    good();
    in_valid = 1'b1; in_data = m_exp;
    reset = 1'b0;
    #1;
    chk("arst_expected", int'(expected), 0);
    chk("arst_word_count", int'(word_count), 0);
    chk("arst_seed_err", int'(seed_err), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0110);
    chk("post_rst_word_count", int'(word_count), 0);
    chk("post_rst_expected", int'(expected), 0);

    @(posedge clock); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
